fib_stack_ctrl: RTL

- Sequencer that computes fib(n) by driving the 128-bit LIFO stack block (pop/push/tos/d_in/d_out/empty) as an explicit recursion stack.
- Work-list algorithm: push n; repeatedly pop x; a leaf (x<2) adds x to the accumulator; otherwise push x-1 and then x-2. Done when the stack is empty.
- Sits between the top-level start/done interface and the stack instance. It is the only master of the stack.

---
 rtl/fib_pkg.sv | 27 ++
 rtl/fib_stack_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fib_pkg.sv
// -----------------------------------------------------------------------------
// fib_pkg
// Shared definitions for the Fibonacci stack sequencer:
//   - default widths and the largest accepted operand
//   - leaf threshold of the recursion (x < 2 is a leaf)
//   - FSM state encoding
// -----------------------------------------------------------------------------
package fib_pkg;

    localparam int DEF_DATA_W = 128;  // stack word width
    localparam int DEF_N_W    = 8;    // operand width
    localparam int DEF_RES_W  = 64;   // accumulator / result width
    localparam int DEF_MAX_N  = 93;   // fib(93) is the largest value fitting 64 bits

    // Values below this are leaves of the recursion and contribute themselves.
    localparam int LEAF_LIMIT = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PUSH_N = 3'd1,
        CHECK  = 3'd2,
        EVAL   = 3'd3,
        PUSH_B = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/fib_stack_ctrl.sv
// -----------------------------------------------------------------------------
// fib_stack_ctrl
// Computes fib(n) with a work-list recursion kept on an external LIFO stack:
// push n; repeatedly pop x; a leaf (x < 2) adds x to the accumulator,
// otherwise x-1 and then x-2 are pushed back. The run ends when the stack
// is empty.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset (shared with the stack)
//   start, n    request and operand, sampled only in IDLE
//   busy        high from the cycle after acceptance through the DONE cycle
//   done, err   single-cycle completion pulse; err marks n > MAX_N
//   result      fib(n), valid from done, held until the next completion
//   st_push, st_pop, st_tos, st_din   stack controls (st_tos tied low)
//   st_dout     stack read data, registered, valid the cycle after pop
//   st_empty    stack empty flag
// -----------------------------------------------------------------------------
module fib_stack_ctrl
    import fib_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_W    = DEF_N_W,
    parameter int RES_W  = DEF_RES_W,
    parameter int MAX_N  = DEF_MAX_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_W-1:0]    n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [RES_W-1:0]  result,
    output logic              st_push,
    output logic              st_pop,
    output logic              st_tos,
    output logic [DATA_W-1:0] st_din,
    input  logic [DATA_W-1:0] st_dout,
    input  logic              st_empty
);

    state_t           state_r;
    state_t           next_s;
    logic [N_W-1:0]   n_reg_r;
    logic [N_W-1:0]   x_reg_r;
    logic [RES_W-1:0] acc_r;
    logic [N_W-1:0]   x_s;
    logic             n_ok_s;
    logic             unused_dout_hi_s;

    // Only the low N_W bits of a stack word ever carry a value.
    assign x_s              = st_dout[N_W-1:0];
    assign unused_dout_hi_s = ^st_dout[DATA_W-1:N_W];
    assign n_ok_s           = (int'(n) <= MAX_N);
    assign st_tos           = 1'b0;

    // Next-state and stack strobe decode; strobes depend on state only
    // (plus the popped value in EVAL), so push and pop are never both high.
    always_comb begin
        next_s  = state_r;
        st_push = 1'b0;
        st_pop  = 1'b0;
        st_din  = '0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (n_ok_s) begin
                        next_s = PUSH_N;
                    end else begin
                        next_s = DONE;
                    end
                end else begin
                    next_s = IDLE;
                end
            end
            PUSH_N: begin
                st_push = 1'b1;
                st_din  = DATA_W'(n_reg_r);
                next_s  = CHECK;
            end
            CHECK: begin
                // Last push/pop was a cycle ago, so the empty flag is settled.
                if (st_empty) begin
                    next_s = DONE;
                end else begin
                    st_pop = 1'b1;
                    next_s = EVAL;
                end
            end
            EVAL: begin
                if (x_s < N_W'(LEAF_LIMIT)) begin
                    next_s = CHECK;
                end else begin
                    st_push = 1'b1;
                    st_din  = DATA_W'(x_s - N_W'(1));
                    next_s  = PUSH_B;
                end
            end
            PUSH_B: begin
                st_push = 1'b1;
                st_din  = DATA_W'(x_reg_r - N_W'(2));
                next_s  = CHECK;
            end
            DONE: begin
                next_s = IDLE;
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // State register, datapath registers and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            n_reg_r <= '0;
            x_reg_r <= '0;
            acc_r   <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_r <= next_s;
            done    <= (next_s == DONE);
            // err can only be raised on the rejection path out of IDLE.
            err     <= (state_r == IDLE) && start && !n_ok_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (n_ok_s) begin
                            n_reg_r <= n;
                            acc_r   <= '0;
                            busy    <= 1'b1;
                        end else begin
                            result  <= '0;
                        end
                    end
                end
                CHECK: begin
                    if (st_empty) begin
                        result <= acc_r;
                    end
                end
                EVAL: begin
                    if (x_s < N_W'(LEAF_LIMIT)) begin
                        acc_r <= acc_r + RES_W'(x_s);
                    end else begin
                        x_reg_r <= x_s;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                    busy <= busy;
                end
            endcase
        end
    end

endmodule
